// File: rtl/shift_sequencer.sv
// Feeds a parallel-load shift register: takes a word over valid/ready, loads it, then
// issues one shift pulse every CLKS_PER_BIT cycles so each bit is held LSB first.
module shift_sequencer #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                fill_bit,
  input  logic                abort,
  output logic [NUM_BITS-1:0] sr_parallel_in,
  output logic                sr_load_enable,
  output logic                sr_shift_enable,
  output logic                sr_serial_in,
  output logic                busy,
  output logic                done
);

  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam int CW = $clog2(NUM_BITS) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_BITS-1:0]   word_q, word_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic                  shift_pulse;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_pulse = (state_q == S_SHIFT) && (baud_q == BAUD_LAST) && !abort;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          word_d  = data_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        baud_d  = '0;
        bit_d   = '0;
        // the load itself is never suppressed; abort only cancels what follows it
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_IDLE;
        end else if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // IDLE is also the reset state, so ready must be masked by rst directly
  assign data_ready      = (state_q == S_IDLE) && !rst;
  assign sr_load_enable  = (state_q == S_LOAD);
  assign sr_shift_enable = shift_pulse;
  assign sr_parallel_in  = word_q;
  assign sr_serial_in    = fill_bit;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: two instances (CLKS_PER_BIT 4 and 1) share stimulus,
// a behavioural shift register model follows the load/shift pulses of the selected one.
module tb_shift_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] data_in;
  logic         data_valid;
  logic         fill_bit;
  logic         abort;
  logic         sel;

  logic         rdy4, ld4, sh4, sin4, busy4, done4;
  logic         rdy1, ld1, sh1, sin1, busy1, done1;
  logic [N-1:0] pin4, pin1;
  logic         val4, val1;

  logic         m_ready, m_load, m_shift, m_sin, m_busy, m_done;
  logic [N-1:0] m_pin;

  assign val4 = data_valid && !sel;
  assign val1 = data_valid && sel;

  shift_sequencer #(.NUM_BITS(N), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(val4), .data_ready(rdy4),
    .fill_bit(fill_bit), .abort(abort), .sr_parallel_in(pin4), .sr_load_enable(ld4),
    .sr_shift_enable(sh4), .sr_serial_in(sin4), .busy(busy4), .done(done4)
  );

  shift_sequencer #(.NUM_BITS(N), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(val1), .data_ready(rdy1),
    .fill_bit(fill_bit), .abort(abort), .sr_parallel_in(pin1), .sr_load_enable(ld1),
    .sr_shift_enable(sh1), .sr_serial_in(sin1), .busy(busy1), .done(done1)
  );

  assign m_ready = sel ? rdy1  : rdy4;
  assign m_load  = sel ? ld1   : ld4;
  assign m_shift = sel ? sh1   : sh4;
  assign m_sin   = sel ? sin1  : sin4;
  assign m_busy  = sel ? busy1 : busy4;
  assign m_done  = sel ? done1 : done4;
  assign m_pin   = sel ? pin1  : pin4;

  typedef struct {
    int         kind;   // 0 load, 1 shift, 2 done
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t          sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           acc_t   = -1;
  int           rdy_cyc = 0;
  logic [N-1:0] model_reg = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit pop_ev(int kind, output ev_t e);
    e = '{kind: -1, cyc: -1, val: 8'h00};
    check("event_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return 1'b0;
    e = sb.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    check("event_cycle", 32'(cyc), 32'(e.cyc));
    return 1'b1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT emits a load, shift or done.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      check("outputs_in_reset", {27'd0, m_ready, m_load, m_shift, m_busy, m_done}, 32'd0);
    end else begin
      check("data_ready", 32'(m_ready), 32'(!(cyc > acc_t && cyc < rdy_cyc)));
      check("busy_vs_ready", 32'(m_busy), 32'(!m_ready));
      if (m_load) begin
        if (pop_ev(0, e)) check("load_word", 32'(m_pin), 32'(e.val));
        model_reg = m_pin;
      end
      if (m_shift) begin
        if (pop_ev(1, e)) begin
          check("serial_out", 32'(model_reg[0]), 32'(e.val[0]));
          check("serial_in", 32'(m_sin), 32'(e.val[1]));
        end
        model_reg = {m_sin, model_reg[N-1:1]};
      end
      if (m_done) begin
        if (pop_ev(2, e)) check("reg_at_done", 32'(model_reg), 32'(e.val));
      end
    end
  end

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_timeout", 32'(got), 32'd1);
  endtask

  // Issue one word; push the whole expected response. abort_off>0 asserts abort at T+abort_off.
  task automatic send(input logic [N-1:0] word, input logic fill, input int abort_off,
                      input bit keep_valid, output int t_acc);
    int  cpb;
    int  a;
    int  dc;
    bit  got = 1'b0;
    cpb = sel ? 1 : 4;
    @(posedge clk);
    #1;
    data_in    = word;
    fill_bit   = fill;
    data_valid = 1'b1;
    t_acc      = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(got), 32'd1);
    t_acc = cyc;
    a  = (abort_off > 0) ? t_acc + abort_off : 32'h7fff_ffff;
    dc = t_acc + 2 + N * cpb;
    sb.push_back('{kind: 0, cyc: t_acc + 1, val: word});
    for (int k = 1; k <= N; k++) begin
      int c = t_acc + 1 + k * cpb;
      if (c < a) sb.push_back('{kind: 1, cyc: c, val: {6'd0, fill, word[k-1]}});
    end
    if (a >= dc) sb.push_back('{kind: 2, cyc: dc, val: {N{fill}}});
    acc_t   = t_acc;
    rdy_cyc = (a == t_acc + 1) ? t_acc + 2 : (a < dc) ? a + 1 : dc + 1;
    @(posedge clk);
    #1;
    if (!keep_valid) data_valid = 1'b0;
    if (abort_off > 0) begin
      while (cyc < a) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
  endtask

  initial begin
    int t1, t2;
    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    fill_bit   = 1'b0;
    abort      = 1'b0;
    sel        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready();

    // 1: 0xA5, done at T+34, ready at T+35
    send(8'hA5, 1'b0, 0, 1'b0, t1);
    wait_ready();
    check("t1_ready_cycle", 32'(cyc), 32'(t1 + 35));

    // 2: fill 1 on an all-zero word leaves 0xFF
    send(8'h00, 1'b1, 0, 1'b0, t1);
    wait_ready();

    // 3: single-cycle bit period
    sel = 1'b1;
    send(8'h3C, 1'b0, 0, 1'b0, t1);
    wait_ready();
    check("t3_ready_cycle", 32'(cyc), 32'(t1 + 11));
    sel = 1'b0;

    // 4: valid held high across two words
    send(8'h11, 1'b0, 0, 1'b1, t1);
    send(8'h22, 1'b0, 0, 1'b0, t2);
    check("t4_second_accept", 32'(t2), 32'(t1 + 35));
    wait_ready();

    // 5: abort on the third shift-pulse cycle, then a normal word
    send(8'hC3, 1'b1, 13, 1'b0, t1);
    wait_ready();
    check("t5_idle_cycle", 32'(cyc), 32'(t1 + 14));
    send(8'h96, 1'b0, 0, 1'b0, t1);
    wait_ready();

    // 6: reset mid-word
    send(8'h5A, 1'b1, 0, 1'b0, t1);
    while (cyc < t1 + 20) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_outputs_drop", {27'd0, m_ready, m_load, m_shift, m_busy, m_done}, 32'd0);
    sb.delete();
    acc_t   = -1;
    rdy_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready_after_rst", 32'(m_ready), 32'd1);
    check("t6_no_load_after_rst", 32'(m_load), 32'd0);
    wait_ready();

    // random words, fills, instances and aborts (abort range spans LOAD..DONE)
    for (int i = 0; i < 14; i++) begin
      int ab;
      sel = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N * (sel ? 1 : 4) + 2)) : 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(N'($urandom), 1'($urandom_range(0, 1)), ab, 1'b0, t1);
      wait_ready();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
